pip_reg_de_ctl: RTL and testbench

// - Decode->Execute pipeline register: stall (hold), flush (bubble insert), per-stage valid bit, async reset.
// - Carries Rs1/Rs2 to the hazard unit and branch funct3; ALU-control and data widths are parametrised.
// - Sits between the decode stage (control unit, register file, immediate extender) and the execute stage (ALU, branch compare).

---
 rtl/pip_pkg.sv | 28 ++
 rtl/pip_field_reg.sv | 42 ++++
 rtl/pip_reg_de_ctl.sv | 182 ++++++++++++++++++
 tb/tb_pip_reg_de_ctl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pip_pkg.sv
// Shared types and constants for the pipeline-register slice.
// Contents:
//   PIP_ALU_CTRL_W  - ALUControl width carried inside ctrl_e_t
//   RES_SRC_*       - writeback mux select encodings
//   ctrl_e_t        - execute-stage control bundle
//   CTRL_BUBBLE     - control value of a bubble (all zero, nothing written)
package pip_pkg;

    localparam int PIP_ALU_CTRL_W = 4;

    localparam logic [1:0] RES_SRC_ALU = 2'b00;
    localparam logic [1:0] RES_SRC_MEM = 2'b01;
    localparam logic [1:0] RES_SRC_PC4 = 2'b10;

    typedef struct packed {
        logic                      RegWrite;
        logic [1:0]                ResultSrc;
        logic                      MemWrite;
        logic                      Jump;
        logic                      Branch;
        logic [2:0]                Funct3;
        logic [PIP_ALU_CTRL_W-1:0] ALUControl;
        logic                      ALUSrc;
    } ctrl_e_t;

    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pip_field_reg.sv
// Async-reset register for one field group of the D->E pipeline register.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - async reset, active-high, clears q_o
//   en_i   - load d_i on the next edge
//   clr_i  - synchronous clear on the next edge, wins over en_i
//   d_i    - next value
//   q_o    - registered value
module pip_field_reg #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pip_reg_de_ctl.sv
// Decode->Execute pipeline register with stall (hold), flush (bubble insert)
// and a per-slot valid bit. Every output is a flop; no D->E combinational path.
// Per-edge priority: rst_i > flush_i > en_i.
// Optional macro PIP_PERF_CNT_EN adds saturating stall/flush counters;
// without it stall_cnt_o/flush_cnt_o are tied to zero and no counter flops exist.
// Ports:
//   clk_i, rst_i           - clock / async active-high reset
//   en_i, flush_i          - 1=load 0=hold / insert bubble
//   *D_i  -> *E_o          - decode-side inputs and their execute-side copies
//                            (valid, control, operands, immediate, PC, indices)
//   stall_cnt_o, flush_cnt_o - performance counters
// ALU_CTRL_WIDTH is expected to equal pip_pkg::PIP_ALU_CTRL_W, since the
// control bundle carries ALUControl at the package width.
module pip_reg_de_ctl
    import pip_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = PIP_ALU_CTRL_W,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      flush_i,

    input  logic                      ValidD_i,
    input  logic                      RegWriteD_i,
    input  logic [1:0]                ResultSrcD_i,
    input  logic                      MemWriteD_i,
    input  logic                      JumpD_i,
    input  logic                      BranchD_i,
    input  logic [2:0]                Funct3D_i,
    input  logic [ALU_CTRL_WIDTH-1:0] ALUControlD_i,
    input  logic                      ALUSrcD_i,
    input  logic [DATA_WIDTH-1:0]     RD1D_i,
    input  logic [DATA_WIDTH-1:0]     RD2D_i,
    input  logic [DATA_WIDTH-1:0]     ImmExtD_i,
    input  logic [PC_WIDTH-1:0]       PCD_i,
    input  logic [PC_WIDTH-1:0]       PCPlus4D_i,
    input  logic [REG_ADDR_WIDTH-1:0] RdD_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D_i,

    output logic                      ValidE_o,
    output logic                      RegWriteE_o,
    output logic [1:0]                ResultSrcE_o,
    output logic                      MemWriteE_o,
    output logic                      JumpE_o,
    output logic                      BranchE_o,
    output logic [2:0]                Funct3E_o,
    output logic [ALU_CTRL_WIDTH-1:0] ALUControlE_o,
    output logic                      ALUSrcE_o,
    output logic [DATA_WIDTH-1:0]     RD1E_o,
    output logic [DATA_WIDTH-1:0]     RD2E_o,
    output logic [DATA_WIDTH-1:0]     ImmExtE_o,
    output logic [PC_WIDTH-1:0]       PCE_o,
    output logic [PC_WIDTH-1:0]       PCPlus4E_o,
    output logic [REG_ADDR_WIDTH-1:0] RdE_o,
    output logic [REG_ADDR_WIDTH-1:0] Rs1E_o,
    output logic [REG_ADDR_WIDTH-1:0] Rs2E_o,

    output logic [CNT_WIDTH-1:0]      stall_cnt_o,
    output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

    localparam int CTRL_W = $bits(ctrl_e_t) + 1;
    localparam int DATA_W = 3 * DATA_WIDTH;
    localparam int PCS_W  = 2 * PC_WIDTH;
    localparam int IDX_W  = 3 * REG_ADDR_WIDTH;

    ctrl_e_t           ctrl_d;
    ctrl_e_t           ctrl_q;
    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_vec_q;
    logic [DATA_W-1:0] data_vec_q;
    logic [PCS_W-1:0]  pc_vec_q;
    logic [IDX_W-1:0]  idx_vec_q;

    always_comb begin
        ctrl_d            = CTRL_BUBBLE;
        ctrl_d.RegWrite   = RegWriteD_i;
        ctrl_d.ResultSrc  = ResultSrcD_i;
        ctrl_d.MemWrite   = MemWriteD_i;
        ctrl_d.Jump       = JumpD_i;
        ctrl_d.Branch     = BranchD_i;
        ctrl_d.Funct3     = Funct3D_i;
        ctrl_d.ALUControl = PIP_ALU_CTRL_W'(ALUControlD_i);
        ctrl_d.ALUSrc     = ALUSrcD_i;
    end

    // Valid travels with the control group so a flush clears both together.
    pip_field_reg #(.WIDTH(CTRL_W)) u_ctrl_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en_i),
        .clr_i (flush_i),
        .d_i   ({ValidD_i, ctrl_d}),
        .q_o   (ctrl_vec_q)
    );

    pip_field_reg #(.WIDTH(DATA_W)) u_data_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en_i),
        .clr_i (flush_i),
        .d_i   ({RD1D_i, RD2D_i, ImmExtD_i}),
        .q_o   (data_vec_q)
    );

    pip_field_reg #(.WIDTH(PCS_W)) u_pc_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en_i),
        .clr_i (flush_i),
        .d_i   ({PCD_i, PCPlus4D_i}),
        .q_o   (pc_vec_q)
    );

    // Bubble clears Rd to x0 so the hazard unit sees no pending write.
    pip_field_reg #(.WIDTH(IDX_W)) u_idx_reg (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (en_i),
        .clr_i (flush_i),
        .d_i   ({RdD_i, Rs1D_i, Rs2D_i}),
        .q_o   (idx_vec_q)
    );

    assign {valid_q, ctrl_q} = ctrl_vec_q;

    assign ValidE_o      = valid_q;
    assign RegWriteE_o   = ctrl_q.RegWrite;
    assign ResultSrcE_o  = ctrl_q.ResultSrc;
    assign MemWriteE_o   = ctrl_q.MemWrite;
    assign JumpE_o       = ctrl_q.Jump;
    assign BranchE_o     = ctrl_q.Branch;
    assign Funct3E_o     = ctrl_q.Funct3;
    assign ALUControlE_o = ALU_CTRL_WIDTH'(ctrl_q.ALUControl);
    assign ALUSrcE_o     = ctrl_q.ALUSrc;

    assign {RD1E_o, RD2E_o, ImmExtE_o} = data_vec_q;
    assign {PCE_o, PCPlus4E_o}         = pc_vec_q;
    assign {RdE_o, Rs1E_o, Rs2E_o}     = idx_vec_q;

`ifdef PIP_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_d;

    // Both counters saturate at all-ones; only reset clears them.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!flush_i && !en_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if (flush_i && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pip_reg_de_ctl.sv
// Directed bench for pip_reg_de_ctl. Counter expectations follow whether
// PIP_PERF_CNT_EN is defined for the build; the DUT uses a 4-bit counter width
// so saturation is reachable quickly.
module tb_pip_reg_de_ctl;
    import pip_pkg::*;

`ifdef PIP_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ValidD_i, RegWriteD_i, MemWriteD_i, JumpD_i, BranchD_i, ALUSrcD_i;
    logic [1:0]  ResultSrcD_i;
    logic [2:0]  Funct3D_i;
    logic [3:0]  ALUControlD_i;
    logic [31:0] RD1D_i, RD2D_i, ImmExtD_i, PCD_i, PCPlus4D_i;
    logic [4:0]  RdD_i, Rs1D_i, Rs2D_i;

    logic        ValidE_o, RegWriteE_o, MemWriteE_o, JumpE_o, BranchE_o, ALUSrcE_o;
    logic [1:0]  ResultSrcE_o;
    logic [2:0]  Funct3E_o;
    logic [3:0]  ALUControlE_o;
    logic [31:0] RD1E_o, RD2E_o, ImmExtE_o, PCE_o, PCPlus4E_o;
    logic [4:0]  RdE_o, Rs1E_o, Rs2E_o;
    logic [3:0]  stall_cnt_o, flush_cnt_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    pip_reg_de_ctl #(
        .DATA_WIDTH(32), .PC_WIDTH(32), .REG_ADDR_WIDTH(5),
        .ALU_CTRL_WIDTH(4), .CNT_WIDTH(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .flush_i(flush_i),
        .ValidD_i(ValidD_i), .RegWriteD_i(RegWriteD_i), .ResultSrcD_i(ResultSrcD_i),
        .MemWriteD_i(MemWriteD_i), .JumpD_i(JumpD_i), .BranchD_i(BranchD_i),
        .Funct3D_i(Funct3D_i), .ALUControlD_i(ALUControlD_i), .ALUSrcD_i(ALUSrcD_i),
        .RD1D_i(RD1D_i), .RD2D_i(RD2D_i), .ImmExtD_i(ImmExtD_i),
        .PCD_i(PCD_i), .PCPlus4D_i(PCPlus4D_i),
        .RdD_i(RdD_i), .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i),
        .ValidE_o(ValidE_o), .RegWriteE_o(RegWriteE_o), .ResultSrcE_o(ResultSrcE_o),
        .MemWriteE_o(MemWriteE_o), .JumpE_o(JumpE_o), .BranchE_o(BranchE_o),
        .Funct3E_o(Funct3E_o), .ALUControlE_o(ALUControlE_o), .ALUSrcE_o(ALUSrcE_o),
        .RD1E_o(RD1E_o), .RD2E_o(RD2E_o), .ImmExtE_o(ImmExtE_o),
        .PCE_o(PCE_o), .PCPlus4E_o(PCPlus4E_o),
        .RdE_o(RdE_o), .Rs1E_o(Rs1E_o), .Rs2E_o(Rs2E_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_all(input logic [31:0] v);
        ValidD_i = v[0]; RegWriteD_i = v[0]; MemWriteD_i = v[0]; JumpD_i = v[0];
        BranchD_i = v[0]; ALUSrcD_i = v[0]; ResultSrcD_i = v[1:0]; Funct3D_i = v[2:0];
        ALUControlD_i = v[3:0]; RD1D_i = v; RD2D_i = v; ImmExtD_i = v;
        PCD_i = v; PCPlus4D_i = v; RdD_i = v[4:0]; Rs1D_i = v[4:0]; Rs2D_i = v[4:0];
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
    endtask

    initial begin
        drive_all(32'hFFFF_FFFF);
        en_i = 1'b1;
        step();
        rst_i = 1'b0;

        // Load all-ones, then assert reset mid-cycle: outputs clear before the next edge.
        step();
        check("load_ones_rd1", RD1E_o, 32'hFFFF_FFFF);
        check("load_ones_valid", ValidE_o, 1'b1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_valid", ValidE_o, 1'b0);
        check("rst_ctrl", {RegWriteE_o, ResultSrcE_o, MemWriteE_o, JumpE_o, BranchE_o,
                           Funct3E_o, ALUControlE_o, ALUSrcE_o}, 14'h0);
        check("rst_data", {RD1E_o, RD2E_o}, 64'h0);
        check("rst_imm_pc", {ImmExtE_o, PCE_o}, 64'h0);
        check("rst_pc4_idx", {PCPlus4E_o, RdE_o, Rs1E_o, Rs2E_o}, {32'h0, 15'h0});
        check("rst_cnt", {stall_cnt_o, flush_cnt_o}, 8'h0);
        step();
        rst_i = 1'b0;

        // Pass-through
        drive_all(32'h0);
        RD1D_i = 32'hDEAD_BEEF; RdD_i = 5'd5; RegWriteD_i = 1'b1; ValidD_i = 1'b1;
        ResultSrcD_i = RES_SRC_MEM; ALUControlD_i = 4'hA; Funct3D_i = 3'd6;
        en_i = 1'b1; flush_i = 1'b0;
        step();
        check("pt_rd1", RD1E_o, 32'hDEAD_BEEF);
        check("pt_rd", RdE_o, 5'd5);
        check("pt_regwrite", RegWriteE_o, 1'b1);
        check("pt_valid", ValidE_o, 1'b1);
        check("pt_misc", {ResultSrcE_o, ALUControlE_o, Funct3E_o, RD2E_o[3:0]}, {2'b01, 4'hA, 3'd6, 4'h0});

        // Invalid slot still loads its fields
        ValidD_i = 1'b0; RD2D_i = 32'h0000_1234; Rs2D_i = 5'd17;
        step();
        check("inv_valid", ValidE_o, 1'b0);
        check("inv_rd2", RD2E_o, 32'h0000_1234);
        check("inv_rs2", Rs2E_o, 5'd17);

        // Stall: PC held for 3 edges
        pulse_reset();
        drive_all(32'h0);
        PCD_i = 32'h100; PCPlus4D_i = 32'h104; ValidD_i = 1'b1;
        step();
        check("stall_load_pc", PCE_o, 32'h100);
        en_i = 1'b0;
        PCD_i = 32'h104; PCPlus4D_i = 32'h108;
        step();
        step();
        step();
        check("stall_pc", PCE_o, 32'h100);
        check("stall_pc4", PCPlus4E_o, 32'h104);
        check("stall_valid", ValidE_o, 1'b1);
        check("stall_cnt3", stall_cnt_o, PERF ? 4'd3 : 4'd0);
        check("stall_fcnt0", flush_cnt_o, 4'd0);

        // Reset in the middle of a stall
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_midstall_pc", PCE_o, 32'h0);
        check("rst_midstall_cnt", stall_cnt_o, 4'd0);
        step();
        rst_i = 1'b0;

        // Flush beats stall
        drive_all(32'h0);
        RegWriteD_i = 1'b1; RdD_i = 5'd7; ValidD_i = 1'b1; PCD_i = 32'h200;
        en_i = 1'b1;
        step();
        check("fl_pre_regwrite", RegWriteE_o, 1'b1);
        check("fl_pre_rd", RdE_o, 5'd7);
        en_i = 1'b0; flush_i = 1'b1;
        step();
        check("fl_regwrite", RegWriteE_o, 1'b0);
        check("fl_valid", ValidE_o, 1'b0);
        check("fl_rd", RdE_o, 5'd0);
        check("fl_pc", PCE_o, 32'h0);
        check("fl_fcnt1", flush_cnt_o, PERF ? 4'd1 : 4'd0);
        check("fl_scnt0", stall_cnt_o, 4'd0);

        // Flush with en=1 and busy D inputs still inserts a bubble
        drive_all(32'hFFFF_FFFF);
        en_i = 1'b1;
        step();
        check("fl_en_ctrl", {ValidE_o, RegWriteE_o, MemWriteE_o, JumpE_o, BranchE_o, ALUSrcE_o}, 6'h0);
        check("fl_en_data", {RD1E_o, ImmExtE_o}, 64'h0);
        check("fl_fcnt2", flush_cnt_o, PERF ? 4'd2 : 4'd0);

        // Counter saturation at 4 bits
        pulse_reset();
        flush_i = 1'b0; en_i = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("sat_stall20", stall_cnt_o, PERF ? 4'd15 : 4'd0);
        step();
        step();
        check("sat_stall22", stall_cnt_o, PERF ? 4'd15 : 4'd0);
        check("sat_fcnt0", flush_cnt_o, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
